// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and a
// range-check helper used by the completer.
package apb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // True when an address falls outside the implemented locations.
    function automatic logic addr_oob(input logic [31:0] addr, input int depth);
        return addr >= 32'(depth);
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage for the APB completer: one synchronous write port,
// one asynchronous read port, whole array cleared while preset is high.
module apb_slave_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update: reset clears every location, otherwise write on we.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small memory with programmable wait states.
// The FSM state records the last bus phase observed; pready/pslverr are
// decoded purely from registered state so no input reaches them combinationally.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    // Keep the counter at least one bit wide even for zero-wait builds.
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    apb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              busy;
    logic              bad_q;
    logic              done;
    logic              setup_now;
    logic              prot_now;
    logic              mem_we;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] mem_rdata;

    assign busy      = (state_q != IDLE);
    assign pready    = busy && (cnt_q == '0);
    assign bad_q     = err_q || addr_oob(32'(addr_q), DEPTH);
    assign pslverr   = pready && bad_q;
    assign done      = pready && psel && penable;
    assign setup_now = psel && !penable;
    assign prot_now  = (state_q == IDLE) && psel && penable;
    assign mem_we    = done && wr_q && !bad_q;
    // A zero-wait read needs the memory addressed by the live bus on the setup edge.
    assign rd_idx    = setup_now ? paddr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    apb_slave_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .pclk   (pclk),
        .preset (preset),
        .we     (mem_we),
        .waddr  (addr_q[IDX_W-1:0]),
        .wdata  (wdata_q),
        .raddr  (rd_idx),
        .rdata  (mem_rdata)
    );

    // Transfer FSM: latch on setup, count wait states, complete or abort,
    // and preload prdata on the edge that enters the completion cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            prdata  <= '0;
        end else if (setup_now) begin
            // New setup phase (from idle or back-to-back); fields frozen here.
            state_q <= SETUP;
            cnt_q   <= CNT_W'(WAIT_STATES);
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            err_q   <= 1'b0;
            if (WAIT_STATES == 0) begin
                if (addr_oob(32'(paddr), DEPTH)) prdata <= '0;
                else if (!pwrite)                prdata <= mem_rdata;
            end
        end else if (prot_now) begin
            // Access phase with no setup: answer with an error, touch nothing.
            state_q <= ACCESS;
            cnt_q   <= '0;
            addr_q  <= paddr;
            wr_q    <= pwrite;
            err_q   <= 1'b1;
            prdata  <= '0;
        end else if (busy) begin
            if (!psel || done) begin
                state_q <= IDLE;
            end else if (cnt_q != '0) begin
                state_q <= ACCESS;
                cnt_q   <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (bad_q)      prdata <= '0;
                    else if (!wr_q) prdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: instance 0 runs with two wait states, instance 1 zero-wait.
// Both share clock, reset and bus fields; each has its own psel.
module tb_apb_slave_mem;
    import apb_pkg::*;

    logic       pclk = 1'b0;
    logic       preset;
    logic       psel0, psel1, penable, pwrite;
    logic [8:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata0, prdata1;
    logic       pready0, pready1, pslverr0, pslverr1;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(256), .WAIT_STATES(2)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) dut1 (
        .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready(input int inst);
        return (inst == 0) ? pready0 : pready1;
    endfunction

    // One complete transfer; fields are scrambled in the access phase so the
    // result depends on the values latched at setup.
    task automatic xfer(input int inst, input logic wr, input logic [8:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output logic err, output int waits);
        @(negedge pclk);
        psel0 = (inst == 0); psel1 = (inst == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1; paddr = ~a; pwdata = ~d; pwrite = ~wr;
        waits = 0;
        while (!cur_ready(inst) && waits < 20) begin
            waits++;
            @(negedge pclk);
        end
        rd  = (inst == 0) ? prdata0 : prdata1;
        err = (inst == 0) ? pslverr0 : pslverr1;
    endtask

    task automatic idle();
        @(negedge pclk);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        int         w;

        preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(negedge pclk);
        check("rst_pready0", 32'(pready0), 0);
        check("rst_pslverr0", 32'(pslverr0), 0);
        check("rst_prdata0", 32'(prdata0), 0);
        check("rst_pready1", 32'(pready1), 0);
        check("rst_pslverr1", 32'(pslverr1), 0);
        check("rst_prdata1", 32'(prdata1), 0);
        preset = 1'b0;

        // 1: two wait states, write then read back
        xfer(0, 1'b1, 9'h010, 8'hA5, rd, err, w);
        check("t1_wr_waits", 32'(w), 2);
        check("t1_wr_err", 32'(err), 0);
        idle();
        xfer(0, 1'b0, 9'h010, 8'h00, rd, err, w);
        check("t1_rd_waits", 32'(w), 2);
        check("t1_rd_data", 32'(rd), 32'hA5);
        check("t1_rd_err", 32'(err), 0);
        idle();

        // 2: zero-wait, back-to-back writes and reads
        xfer(1, 1'b1, 9'h001, 8'h11, rd, err, w);
        check("t2_wr1_waits", 32'(w), 0);
        check("t2_wr1_err", 32'(err), 0);
        xfer(1, 1'b1, 9'h002, 8'h22, rd, err, w);
        check("t2_wr2_waits", 32'(w), 0);
        xfer(1, 1'b0, 9'h001, 8'h00, rd, err, w);
        check("t2_rd1_waits", 32'(w), 0);
        check("t2_rd1_data", 32'(rd), 32'h11);
        xfer(1, 1'b0, 9'h002, 8'h00, rd, err, w);
        check("t2_rd2_data", 32'(rd), 32'h22);
        check("t2_rd2_err", 32'(err), 0);
        idle();

        // 3: out-of-range address, aliasing location must stay untouched
        xfer(0, 1'b1, 9'h100, 8'h5A, rd, err, w);
        check("t3_wr_waits", 32'(w), 2);
        check("t3_wr_err", 32'(err), 1);
        idle();
        xfer(0, 1'b0, 9'h100, 8'h00, rd, err, w);
        check("t3_rd_data", 32'(rd), 0);
        check("t3_rd_err", 32'(err), 1);
        idle();
        xfer(0, 1'b0, 9'h000, 8'h00, rd, err, w);
        check("t3_alias_data", 32'(rd), 0);
        check("t3_alias_err", 32'(err), 0);
        idle();

        // 4: access phase straight from idle
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h030; pwdata = 8'h77;
        @(negedge pclk);
        check("t4_pready", 32'(pready0), 1);
        check("t4_pslverr", 32'(pslverr0), 1);
        idle();
        xfer(0, 1'b0, 9'h030, 8'h00, rd, err, w);
        check("t4_rd_data", 32'(rd), 0);
        check("t4_rd_err", 32'(err), 0);
        idle();

        // 5: psel dropped during the first wait cycle
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'h33;
        @(negedge pclk);
        penable = 1'b1;
        check("t5_wait_pready", 32'(pready0), 0);
        @(negedge pclk);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("t5_abort_pready", 32'(pready0), 0);
        check("t5_abort_state", 32'(dut0.state_q), 32'(IDLE));
        xfer(0, 1'b0, 9'h020, 8'h00, rd, err, w);
        check("t5_rd_data", 32'(rd), 0);
        idle();

        // 6: reset in the middle of an access
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 8'h99;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        check("t6_pready", 32'(pready0), 0);
        check("t6_pslverr", 32'(pslverr0), 0);
        check("t6_state", 32'(dut0.state_q), 32'(IDLE));
        check("t6_prdata", 32'(prdata0), 0);
        preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
        xfer(0, 1'b0, 9'h010, 8'h00, rd, err, w);
        check("t6_rd_data", 32'(rd), 0);
        check("t6_rd_err", 32'(err), 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
